// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the synchronous data memory: one request at a time, IDLE -> ACCESS -> RESP.
// Optional per-kind response counters are compiled in when LSU_PERF_CNT_EN is defined.
module lsu_mem_initiator #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_errs
`endif
);

  // state  | meaning
  // IDLE   | waiting for a request
  // ACCESS | address/strobes on the memory port for one cycle
  // RESP   | response held until resp_ready
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              r_we, r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              f3_legal, misalign, dec_err;
  logic [1:0]        off;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_rep, rd_shift, load_ext;
  logic [ADDR_W-1:0] addr_aligned;

  always_comb begin
    f3_legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                      : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    dec_err  = !f3_legal || misalign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        r_we    <= req_we;
        r_err   <= dec_err;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = dec_err ? RESP : ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    off          = r_addr[1:0];
    addr_aligned = {r_addr[ADDR_W-1:2], 2'b00};
    case (r_f3[1:0])
      2'b00:   begin be_calc = 4'b0001 << off; wdata_rep = {4{r_wdata[7:0]}};  end
      2'b01:   begin be_calc = 4'b0011 << off; wdata_rep = {2{r_wdata[15:0]}}; end
      default: begin be_calc = 4'b1111;        wdata_rep = r_wdata;            end
    endcase
    rd_shift = mem_rdata >> {off, 3'b000};
    case (r_f3)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  load_ext = {24'd0, rd_shift[7:0]};
      3'b101:  load_ext = {16'd0, rd_shift[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    case (state_q)
      IDLE: req_ready = !rst;
      ACCESS: begin
        mem_addr  = addr_aligned;
        mem_be    = be_calc;
        mem_wdata = wdata_rep;
        mem_we    = r_we;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        // address stays up so the registered read data remains stable under backpressure
        mem_addr   = r_err ? '0 : addr_aligned;
        resp_rdata = (!r_we && !r_err) ? load_ext : '0;
      end
      default: ;
    endcase
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (resp_valid && resp_ready) begin
      if (r_err)     perf_errs   <= perf_errs + 32'd1;
      else if (r_we) perf_stores <= perf_stores + 32'd1;
      else           perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit on the CPU side of the data-memory port; it is the initiator that drives the synchronous data memory.
- Accepts one load or store request at a time from the execute stage through a valid/ready handshake.
- Converts each request into a word-aligned memory access with byte enables, waits out the memory's one-cycle registered read latency, then returns sign- or zero-extended load data.
- Flags misaligned and illegal-size accesses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3.
- mem_addr  out  ADDR_W  word-aligned address; bits[1:0] always 0.
- mem_we  out  1  memory write strobe.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read data, valid the cycle after the address is presented.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - While rst is high: state IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_we=0, mem_be=0, mem_wdata=0.
  - Asserting rst mid-access aborts it: no write issued after rst rises, no response produced.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready at edge T, register the request fields and decode.
    - Legal request -> ACCESS in T+1.
    - Illegal request -> RESP in T+1 with resp_err=1.
  - ACCESS (one cycle): drive mem_addr={addr[31:2],2'b00}, mem_be, mem_wdata; mem_we=1 only for stores. Always -> RESP.
  - RESP: resp_valid=1, mem_we=0, mem_addr held so mem_rdata stays stable.
    - Load data is extracted combinationally from mem_rdata.
    - Stay in RESP until resp_ready=1, then -> IDLE.
  - req_ready=0 in ACCESS and RESP.
- Latency: acceptance at T; memory access at T+1; response visible at T+2 (T+1 for errors). Back-to-back throughput is one request per 3 cycles when resp_ready is held at 1.
- funct3 decode:
  - 000 byte signed; 001 half signed; 010 word; 100 byte unsigned; 101 half unsigned.
  - 011, 110, 111 are illegal. For stores, only 000/001/010 are legal.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Violations set resp_err=1, produce no memory access, and return resp_rdata=0.
- Byte lanes (little-endian, off = addr[1:0]):
  - Byte: be = 4'b0001<<off; wdata = {4{wdata[7:0]}}.
  - Half: be = 4'b0011<<off; wdata = {2{wdata[15:0]}}.
  - Word: be = 4'b1111.
  - mem_be=0 outside ACCESS.
- Load extract: the selected lane is shifted down by 8*off, then sign-extended (000/001) or zero-extended (100/101). Word loads return mem_rdata unmodified.
- Stores: resp_rdata=0, resp_err=0 in RESP.
- Handshake:
  - req_valid may fall without acceptance; no stall is implied.
  - resp_valid, once raised, holds with stable data until resp_ready is sampled high.
  - resp_ready high outside RESP is ignored.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: adds outputs perf_loads[31:0], perf_stores[31:0], perf_errs[31:0].
  - Each increments by 1 on a response handshake (resp_valid&resp_ready) of the matching kind.
  - Errored requests count only in perf_errs.
  - Counters wrap 0xFFFFFFFF -> 0 and clear on rst.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Word store addr=0x10, wdata=0xDEADBEEF, funct3=010 -> at T+1: mem_we=1, mem_addr=0x10, mem_be=1111, mem_wdata=0xDEADBEEF; at T+2: resp_valid=1, resp_err=0.
- Signed byte load addr=0x13, funct3=000, mem_rdata=0x80FF_1234 -> mem_be=1000, resp_rdata=0xFFFFFF80. Same access with funct3=100 -> 0x00000080.
- Half store addr=0x22, wdata=0x0000ABCD -> mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD. Then signed half load from addr=0x22 with mem_rdata=0xABCD0000 -> resp_rdata=0xFFFFABCD.
- Misaligned word load addr=0x06 -> mem_we=0 and mem_be=0 throughout; resp_valid at T+1 with resp_err=1, resp_rdata=0. Repeat with funct3=011 -> same error response.
- Backpressure: hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0, mem_we=0. Raise resp_ready -> IDLE next cycle and a new request is accepted.
- Assert rst during ACCESS of a store -> mem_we falls immediately, all outputs return to reset values, and no response is produced. With LSU_PERF_CNT_EN, counters read 0 after rst, then 1 load + 1 store + 1 error gives 1/1/1.
